t03_writeback_unit: RTL and testbench

Parametrised, registered writeback stage for the team_03 RISC-V core. Accepts one retiring instruction per cycle from the memory stage and selects the result source: ALU, PC+4, signed/unsigned set-less-than, or a load with byte/half/word sign or zero extension. Loads wait for a memory response, guarded by a timeout counter. Drives the register-file write port one cycle after the result is known.

---
 rtl/t03_wb_pkg.sv | 33 +++
 rtl/t03_writeback_unit_if.sv | 38 +++
 rtl/t03_load_extend.sv | 25 ++
 rtl/t03_writeback_unit.sv | 123 ++++++++++++
 tb/tb_t03_writeback_unit.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/t03_wb_pkg.sv
// Shared types for the team_03 writeback stage and its load-extension helper.
package t03_wb_pkg;

    localparam int unsigned SEL_W  = 2;
    localparam int unsigned SIZE_W = 2;

    // Result source selected by the memory stage
    typedef enum logic [SEL_W-1:0] {
        SEL_ALU = 2'b00,
        SEL_MEM = 2'b01,
        SEL_PC4 = 2'b10,
        SEL_SLT = 2'b11
    } wb_sel_e;

    // Load access size; encoding 2'b11 is handled as a word access
    typedef enum logic [SIZE_W-1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } ld_size_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_e;

    // Load context captured at accept time and used when the response arrives
    typedef struct packed {
        logic [SIZE_W-1:0] size;
        logic              uns;
    } ld_ctx_t;

endpackage

// File: rtl/t03_writeback_unit_if.sv
// Memory-stage to writeback bundle plus the register-file write port.
interface t03_writeback_unit_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rd;
    logic [1:0]        in_sel;
    logic [1:0]        in_size;
    logic              in_unsigned;
    logic [XLEN-1:0]   alu_value;
    logic [XLEN-1:0]   pc_4_value;
    logic              alu_neg;
    logic              alu_overflow;
    logic              alu_borrow;
    logic              mem_valid;
    logic [XLEN-1:0]   mem_data;
    logic              reg_we;
    logic [REG_AW-1:0] reg_addr;
    logic [XLEN-1:0]   reg_wdata;

    // Upstream pipeline / memory side
    modport master (
        output in_valid, in_rd, in_sel, in_size, in_unsigned,
               alu_value, pc_4_value, alu_neg, alu_overflow, alu_borrow,
               mem_valid, mem_data,
        input  in_ready, reg_we, reg_addr, reg_wdata
    );

    // Writeback unit side
    modport slave (
        input  in_valid, in_rd, in_sel, in_size, in_unsigned,
               alu_value, pc_4_value, alu_neg, alu_overflow, alu_borrow,
               mem_valid, mem_data,
        output in_ready, reg_we, reg_addr, reg_wdata
    );
endinterface

// File: rtl/t03_load_extend.sv
// Combinational byte/half/word load extension; shared with the LSU.
module t03_load_extend
    import t03_wb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]   data,
    input  logic [SIZE_W-1:0] size,
    input  logic              load_unsigned,
    output logic [XLEN-1:0]   ext_value
);

    // Size casts of signed operands sign-extend, so no replication is needed
    always_comb begin
        ext_value = data;
        case (ld_size_e'(size))
            SZ_BYTE: ext_value = load_unsigned ? XLEN'(data[7:0])
                                               : XLEN'($signed(data[7:0]));
            SZ_HALF: ext_value = load_unsigned ? XLEN'(data[15:0])
                                               : XLEN'($signed(data[15:0]));
            default: ext_value = data;
        endcase
    end

endmodule

// File: rtl/t03_writeback_unit.sv
// Registered writeback stage: result mux, load wait FSM with timeout, RF write port.
module t03_writeback_unit
    import t03_wb_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    t03_writeback_unit_if.slave  wb,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned CNT_W   = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned TO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

    wb_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    ld_ctx_t           ld_q, ld_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              reg_we_q, reg_we_d;
    logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
    logic [XLEN-1:0]   reg_wdata_q, reg_wdata_d;
    logic              timeout_err_q, timeout_err_d;
    logic [XLEN-1:0]   result_c;
    logic [XLEN-1:0]   load_value_c;

    t03_load_extend #(.XLEN(XLEN)) u_load_extend (
        .data          (wb.mem_data),
        .size          (ld_q.size),
        .load_unsigned (ld_q.uns),
        .ext_value     (load_value_c)
    );

    // Non-load result selection; SLT picks signed or unsigned compare flag
    always_comb begin
        result_c = wb.alu_value;
        case (wb_sel_e'(wb.in_sel))
            SEL_PC4: result_c = wb.pc_4_value;
            SEL_SLT: result_c = XLEN'(wb.in_unsigned ? wb.alu_borrow
                                                     : (wb.alu_neg ^ wb.alu_overflow));
            default: result_c = wb.alu_value;
        endcase
    end

    // Next-state, timeout counter and write-port update
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ld_d          = ld_q;
        rd_d          = rd_q;
        reg_we_d      = 1'b0;
        reg_addr_d    = reg_addr_q;
        reg_wdata_d   = reg_wdata_q;
        timeout_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wb.in_valid) begin
                    if (wb_sel_e'(wb.in_sel) == SEL_MEM) begin
                        state_d  = ST_WAIT_MEM;
                        cnt_d    = '0;
                        rd_d     = wb.in_rd;
                        ld_d.size = wb.in_size;
                        ld_d.uns  = wb.in_unsigned;
                    end else if (wb.in_rd != '0) begin
                        reg_we_d    = 1'b1;
                        reg_addr_d  = wb.in_rd;
                        reg_wdata_d = result_c;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (wb.mem_valid) begin
                    state_d = ST_IDLE;
                    if (rd_q != '0) begin
                        reg_we_d    = 1'b1;
                        reg_addr_d  = rd_q;
                        reg_wdata_d = load_value_c;
                    end
                end else if ((MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            ld_q          <= '0;
            rd_q          <= '0;
            reg_we_q      <= 1'b0;
            reg_addr_q    <= '0;
            reg_wdata_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ld_q          <= ld_d;
            rd_q          <= rd_d;
            reg_we_q      <= reg_we_d;
            reg_addr_q    <= reg_addr_d;
            reg_wdata_q   <= reg_wdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign wb.in_ready    = (state_q == ST_IDLE);
    assign busy           = (state_q == ST_WAIT_MEM);
    assign wb.reg_we      = reg_we_q;
    assign wb.reg_addr    = reg_addr_q;
    assign wb.reg_wdata   = reg_wdata_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_t03_writeback_unit.sv
// Randomized bench for t03_writeback_unit against a transaction-level reference model.
module tb_t03_writeback_unit;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned REG_AW      = 5;
    localparam int unsigned MEM_TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic timeout_err;

    t03_writeback_unit_if #(.XLEN(XLEN), .REG_AW(REG_AW)) wb ();

    t03_writeback_unit #(
        .XLEN        (XLEN),
        .REG_AW      (REG_AW),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb          (wb),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending load bookkeeping and expected port values
    bit          m_wait;
    int          m_waited;
    int          m_rd;
    int          m_size;
    bit          m_uns;
    bit          e_we;
    bit          e_err;
    logic [4:0]  e_addr;
    logic [31:0] e_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] d, input int size, input bit uns);
        longint v;
        v = longint'(d);
        if (size == 0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (size == 1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_result();
        case (wb.in_sel)
            2'b10:   return wb.pc_4_value;
            2'b11:   begin
                if (wb.in_unsigned) return wb.alu_borrow ? 32'd1 : 32'd0;
                return (wb.alu_neg != wb.alu_overflow) ? 32'd1 : 32'd0;
            end
            default: return wb.alu_value;
        endcase
    endfunction

    task automatic model_reset();
        m_wait   = 0;
        m_waited = 0;
        e_we     = 0;
        e_err    = 0;
        e_addr   = '0;
        e_wdata  = '0;
    endtask

    task automatic check_outputs();
        check("reg_we",      64'(wb.reg_we),    64'(e_we));
        check("reg_addr",    64'(wb.reg_addr),  64'(e_addr));
        check("reg_wdata",   64'(wb.reg_wdata), 64'(e_wdata));
        check("timeout_err", 64'(timeout_err),  64'(e_err));
        check("busy",        64'(busy),         64'(m_wait));
        check("in_ready",    64'(wb.in_ready),  64'(!m_wait));
    endtask

    // Advance the model by one clock using the inputs currently driven, then compare
    task automatic step();
        e_we  = 0;
        e_err = 0;
        if (!m_wait) begin
            if (wb.in_valid) begin
                if (wb.in_sel == 2'b01) begin
                    m_wait   = 1;
                    m_waited = 0;
                    m_rd     = int'(wb.in_rd);
                    m_size   = int'(wb.in_size);
                    m_uns    = wb.in_unsigned;
                end else if (wb.in_rd != 0) begin
                    e_we    = 1;
                    e_addr  = wb.in_rd;
                    e_wdata = ref_result();
                end
            end
        end else if (wb.mem_valid) begin
            m_wait = 0;
            if (m_rd != 0) begin
                e_we    = 1;
                e_addr  = 5'(m_rd);
                e_wdata = ref_load(wb.mem_data, m_size, m_uns);
            end
        end else begin
            m_waited++;
            if (m_waited == int'(MEM_TIMEOUT)) begin
                m_wait = 0;
                e_err  = 1;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive_idle();
        wb.in_valid     = 1'b0;
        wb.in_rd        = 5'($urandom);
        wb.in_sel       = 2'($urandom);
        wb.in_size      = 2'($urandom);
        wb.in_unsigned  = 1'($urandom);
        wb.alu_value    = $urandom;
        wb.pc_4_value   = $urandom;
        wb.alu_neg      = 1'($urandom);
        wb.alu_overflow = 1'($urandom);
        wb.alu_borrow   = 1'($urandom);
        wb.mem_valid    = 1'b0;
        wb.mem_data     = $urandom;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [1:0] sel,
                         input logic [1:0] size, input logic uns);
        drive_idle();
        wb.in_valid    = 1'b1;
        wb.in_rd       = rd;
        wb.in_sel      = sel;
        wb.in_size     = size;
        wb.in_unsigned = uns;
    endtask

    task automatic respond(input logic [31:0] data);
        drive_idle();
        wb.mem_valid = 1'b1;
        wb.mem_data  = data;
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        check("reset_ready", 64'(wb.in_ready), 64'd1);
        rst = 1'b0;

        // ALU write
        issue(5'd5, 2'b00, 2'b00, 1'b0);
        wb.alu_value = 32'h1234_5678;
        step();
        check("alu_wdata", 64'(wb.reg_wdata), 64'h1234_5678);
        drive_idle();
        step();

        // Signed byte load after two wait cycles
        issue(5'd3, 2'b01, 2'b00, 1'b0);
        step();
        drive_idle(); step();
        drive_idle(); step();
        respond(32'hAABB_CC80);
        step();
        check("lb_wdata", 64'(wb.reg_wdata), 64'hFFFF_FF80);

        // Unsigned half load
        issue(5'd3, 2'b01, 2'b01, 1'b1);
        step();
        drive_idle(); step();
        drive_idle(); step();
        respond(32'hAABB_CC80);
        step();
        check("lhu_wdata", 64'(wb.reg_wdata), 64'h0000_CC80);

        // SLT / SLTU, back to back
        issue(5'd8, 2'b11, 2'b00, 1'b0);
        wb.alu_neg = 1'b1; wb.alu_overflow = 1'b1;
        step();
        check("slt_n1_o1", 64'(wb.reg_wdata), 64'd0);
        issue(5'd9, 2'b11, 2'b00, 1'b0);
        wb.alu_neg = 1'b1; wb.alu_overflow = 1'b0;
        step();
        check("slt_n1_o0", 64'(wb.reg_wdata), 64'd1);
        issue(5'd10, 2'b11, 2'b00, 1'b1);
        wb.alu_borrow = 1'b1;
        step();
        check("sltu_b1", 64'(wb.reg_wdata), 64'd1);
        issue(5'd11, 2'b10, 2'b00, 1'b0);
        step();
        check("b2b_we", 64'(wb.reg_we), 64'd1);
        drive_idle();
        step();

        // Timeout with no response
        issue(5'd7, 2'b01, 2'b10, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive_idle();
            step();
        end
        check("to_err", 64'(timeout_err), 64'd1);
        check("to_no_we", 64'(wb.reg_we), 64'd0);
        drive_idle();
        step();

        // Response in the expiry cycle wins
        issue(5'd12, 2'b01, 2'b10, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive_idle();
            step();
        end
        respond(32'hDEAD_BEEF);
        step();
        check("late_wdata", 64'(wb.reg_wdata), 64'hDEAD_BEEF);
        check("late_no_err", 64'(timeout_err), 64'd0);

        // Reset during WAIT_MEM, then a stale response
        issue(5'd13, 2'b01, 2'b00, 1'b0);
        step();
        drive_idle();
        step();
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
        respond(32'h0000_00FF);
        step();
        drive_idle();
        step();

        // Destination x0 never writes
        issue(5'd0, 2'b00, 2'b00, 1'b0);
        step();
        issue(5'd0, 2'b01, 2'b10, 1'b0);
        step();
        respond(32'h1111_2222);
        step();
        check("x0_no_we", 64'(wb.reg_we), 64'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            drive_idle();
            wb.in_valid  = ($urandom_range(0, 9) < 6);
            wb.mem_valid = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 7) == 0) wb.in_rd = 5'd0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
